// File: rtl/pet_need_scheduler.sv
// Pet need/condition flag generator: per-need age counters paced by a frame-tick prescaler,
// item pulses clear needs, neglect escalates to dying and then death.
module pet_need_scheduler #(
  parameter int TICKS_PER_STEP = 60,
  parameter int HUNGER_PERIOD  = 8,
  parameter int BORED_PERIOD   = 6,
  parameter int DIRTY_PERIOD   = 10,
  parameter int SICK_PERIOD    = 12,
  parameter int SICK_GRACE     = 4,
  parameter int DEATH_STEPS    = 5,
  parameter int SLEEP_STEPS    = 3,
  parameter int CW             = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       game_active,
  input  logic       frame_tick,
  input  logic       ballGiven,
  input  logic       foodGiven,
  input  logic       broomGiven,
  input  logic       pillsGiven,
  input  logic       firstAidGiven,
  output logic       hungerenable,
  output logic       boredenable,
  output logic       sickenable,
  output logic       dirtyenable,
  output logic       dyingenable,
  output logic       zzzsenable,
  output logic       deceased,
  output logic [2:0] need_count
);

  // state    | meaning
  // S_IDLE   | game screen not running, everything held at 0
  // S_AWAKE  | needs age, idle steps counted toward sleep
  // S_ASLEEP | needs keep aging, any new need or item wakes the pet
  // S_DYING  | death countdown running, first aid rescues
  // S_DEAD   | terminal until game_active drops
  typedef enum logic [2:0] {S_IDLE, S_AWAKE, S_ASLEEP, S_DYING, S_DEAD} state_t;

  localparam int NH = 0;
  localparam int NB = 1;
  localparam int NS = 2;
  localparam int ND = 3;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TPS_M1   = CW'(TICKS_PER_STEP - 1);
  localparam logic [CW-1:0] GRACE_M1 = CW'(SICK_GRACE - 1);
  localparam logic [CW-1:0] SLEEP_M1 = CW'(SLEEP_STEPS - 1);
  localparam logic [CW-1:0] DEATH_LD = CW'(DEATH_STEPS);
  localparam logic [3:0][CW-1:0] PERIOD_M1 = {CW'(DIRTY_PERIOD - 1), CW'(SICK_PERIOD - 1),
                                              CW'(BORED_PERIOD - 1), CW'(HUNGER_PERIOD - 1)};

  state_t              state_q, state_d;
  logic [CW-1:0]       presc_q, presc_d;
  logic [3:0][CW-1:0]  age_q, age_d;
  logic [3:0]          flag_q, flag_d;
  logic [CW-1:0]       sick_cnt_q, sick_cnt_d;
  logic [CW-1:0]       idle_cnt_q, idle_cnt_d;
  logic [CW-1:0]       death_cnt_q, death_cnt_d;
  logic [4:0]          item_q, item_qq, item_edge;
  logic [3:0]          clr;
  logic                active, step, aid_edge;
  logic                dying_q, zzzs_q, deceased_q;
  logic [2:0]          need_count_q, need_count_d;

  // item bit order: 0 food, 1 ball, 2 broom, 3 pills, 4 first aid
  assign item_edge = item_q & ~item_qq;
  assign aid_edge  = item_edge[4];
  assign clr[NH]   = item_edge[0];
  assign clr[NB]   = item_edge[1];
  assign clr[ND]   = item_edge[2];
  assign clr[NS]   = item_edge[3];

  assign active = (state_q == S_AWAKE) || (state_q == S_ASLEEP) || (state_q == S_DYING);
  assign step   = active && frame_tick && (presc_q == TPS_M1);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    age_d       = age_q;
    flag_d      = flag_q;
    sick_cnt_d  = sick_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    death_cnt_d = death_cnt_q;

    if (active && frame_tick) presc_d = step ? '0 : presc_q + ONE;

    if (active) begin
      for (int i = 0; i < 4; i++) begin
        if (step && !flag_q[i]) begin
          if (age_q[i] == PERIOD_M1[i]) begin
            flag_d[i] = 1'b1;
            age_d[i]  = '0;
          end else begin
            age_d[i] = age_q[i] + ONE;
          end
        end
        // an item on the same cycle as the flag-set wins
        if (clr[i]) begin
          flag_d[i] = 1'b0;
          age_d[i]  = '0;
        end
      end
    end

    unique case (state_q)
      S_IDLE: if (game_active) state_d = S_AWAKE;
      S_AWAKE: begin
        if (step && ((flag_q[NS] && sick_cnt_q == GRACE_M1) || need_count_q >= 3'd3)) begin
          state_d     = S_DYING;
          death_cnt_d = DEATH_LD;
          idle_cnt_d  = '0;
        end else if (|flag_d) begin
          idle_cnt_d = '0;
        end else if (step) begin
          if (idle_cnt_q == SLEEP_M1) begin
            state_d    = S_ASLEEP;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + ONE;
          end
        end
      end
      S_ASLEEP: begin
        idle_cnt_d = '0;
        if ((|(flag_d & ~flag_q)) || (|item_edge)) state_d = S_AWAKE;
      end
      S_DYING: begin
        if (aid_edge) begin
          state_d     = S_AWAKE;
          flag_d[NS]  = 1'b0;
          age_d[NS]   = '0;
          death_cnt_d = '0;
        end else if (step) begin
          death_cnt_d = death_cnt_q - ONE;
          if (death_cnt_q == ONE) begin
            state_d = S_DEAD;
            flag_d  = '0;
            age_d   = age_q;
          end
        end
      end
      S_DEAD:  state_d = S_DEAD;
      default: state_d = S_IDLE;
    endcase

    if (!flag_d[NS])                sick_cnt_d = '0;
    else if (step && flag_q[NS])    sick_cnt_d = sick_cnt_q + ONE;

    if (!game_active) begin
      state_d     = S_IDLE;
      presc_d     = '0;
      age_d       = '0;
      flag_d      = '0;
      sick_cnt_d  = '0;
      idle_cnt_d  = '0;
      death_cnt_d = '0;
    end
  end

  assign need_count_d = {2'b00, flag_d[0]} + {2'b00, flag_d[1]} + {2'b00, flag_d[2]} + {2'b00, flag_d[3]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      age_q        <= '0;
      flag_q       <= '0;
      sick_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      death_cnt_q  <= '0;
      item_q       <= '0;
      item_qq      <= '0;
      dying_q      <= 1'b0;
      zzzs_q       <= 1'b0;
      deceased_q   <= 1'b0;
      need_count_q <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      age_q        <= age_d;
      flag_q       <= flag_d;
      sick_cnt_q   <= sick_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      death_cnt_q  <= death_cnt_d;
      item_q       <= {firstAidGiven, pillsGiven, broomGiven, ballGiven, foodGiven};
      item_qq      <= item_q;
      dying_q      <= (state_d == S_DYING);
      zzzs_q       <= (state_d == S_ASLEEP);
      deceased_q   <= (state_d == S_DEAD);
      need_count_q <= need_count_d;
    end
  end

  assign hungerenable = flag_q[NH];
  assign boredenable  = flag_q[NB];
  assign sickenable   = flag_q[NS];
  assign dirtyenable  = flag_q[ND];
  assign dyingenable  = dying_q;
  assign zzzsenable   = zzzs_q;
  assign deceased     = deceased_q;
  assign need_count   = need_count_q;

endmodule

// File: tb/tb_pet_need_scheduler.sv
// Scenario bench for pet_need_scheduler with short periods; expected output vectors are queued
// when stimulus is applied and compared once the DUT has responded.
module tb_pet_need_scheduler;
  logic clk = 1'b0;
  logic resetn, game_active, frame_tick;
  logic ballGiven, foodGiven, broomGiven, pillsGiven, firstAidGiven;
  logic hungerenable, boredenable, sickenable, dirtyenable, dyingenable, zzzsenable, deceased;
  logic [2:0] need_count;
  logic [9:0] obs;

  typedef struct { string name; logic [9:0] exp; logic [9:0] mask; } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  localparam logic [9:0] ALL    = 10'h3FF;
  localparam logic [9:0] HMASK  = 10'h200;
  localparam logic [4:0] KEEP   = 5'b00111;
  localparam logic [4:0] AID    = 5'b10000;

  pet_need_scheduler #(
    .TICKS_PER_STEP(2), .HUNGER_PERIOD(3), .BORED_PERIOD(5), .DIRTY_PERIOD(7),
    .SICK_PERIOD(7), .SICK_GRACE(2), .DEATH_STEPS(2), .SLEEP_STEPS(2), .CW(8)
  ) dut (
    .clk(clk), .resetn(resetn), .game_active(game_active), .frame_tick(frame_tick),
    .ballGiven(ballGiven), .foodGiven(foodGiven), .broomGiven(broomGiven),
    .pillsGiven(pillsGiven), .firstAidGiven(firstAidGiven),
    .hungerenable(hungerenable), .boredenable(boredenable), .sickenable(sickenable),
    .dirtyenable(dirtyenable), .dyingenable(dyingenable), .zzzsenable(zzzsenable),
    .deceased(deceased), .need_count(need_count)
  );

  always #5 clk = ~clk;

  // {hunger, bored, sick, dirty, dying, zzzs, deceased, need_count[2:0]}
  assign obs = {hungerenable, boredenable, sickenable, dirtyenable, dyingenable, zzzsenable, deceased, need_count};

  function automatic void push(input string n, input logic [9:0] x, input logic [9:0] m);
    exp_t t;
    t.name = n;
    t.exp  = x;
    t.mask = m;
    sb.push_back(t);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // one step whose item edges land on the same edge as the step pulse
  task automatic item_step(input logic [4:0] m);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    {firstAidGiven, pillsGiven, broomGiven, ballGiven, foodGiven} = m;
    cycle();
    {firstAidGiven, pillsGiven, broomGiven, ballGiven, foodGiven} = 5'b0;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  task automatic restart();
    game_active = 1'b0;
    cycle();
    game_active = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    push("reset_async", 10'h000, ALL);
    #2;
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("reset_idle", 10'h000, ALL);
    @(posedge clk); #1;
    resetn = 1'b1;
    cycle();
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
  endtask

  task automatic test_hunger_set();
    game_active = 1'b1;
    cycle();
    push("t1_after5_asleep", 10'h010, ALL);
    ticks(5);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t1_hunger_set", 10'h201, ALL);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
  endtask

  task automatic test_food_clear();
    restart();
    ticks(6);
    push("t2_food_wait", 10'h200, HMASK);
    foodGiven = 1'b1;
    cycle();
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t2_food_cleared", 10'h000, ALL);
    cycle();
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    foodGiven = 1'b0;
    cycle();
    push("t2_rearm_5", 10'h000, HMASK);
    ticks(5);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t2_rearm_6", 10'h302, ALL);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
  endtask

  task automatic test_item_vs_set();
    restart();
    ticks(4);
    push("t3_coincide", 10'h000, ALL);
    item_step(5'b00001);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t3_after5", 10'h000, HMASK);
    ticks(5);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t3_after6", 10'h302, ALL);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t3_game_off", 10'h000, ALL);
    game_active = 1'b0;
    cycle();
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
  endtask

  task automatic test_sleep();
    restart();
    push("t4_step1_awake", 10'h000, ALL);
    item_step(5'b00011);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t4_step2_asleep", 10'h010, ALL);
    item_step(5'b00011);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t4_still_asleep", 10'h010, ALL);
    ticks(4);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t4_wake_on_need", 10'h201, ALL);
    ticks(2);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
  endtask

  task automatic test_dying(input logic rescue);
    restart();
    for (int k = 0; k < 7; k++) item_step(KEEP);
    push("t5_sick_grace", 10'h081, ALL);
    item_step(KEEP);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t5_dying", 10'h0A1, ALL);
    item_step(KEEP);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    push("t5_dying_cnt1", 10'h0A1, ALL);
    item_step(KEEP);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    if (rescue) begin
      push("t5_first_aid", 10'h000, ALL);
      item_step(KEEP | AID);
      e = sb.pop_front(); checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    end else begin
      push("t5_dead", 10'h008, ALL);
      push("t5_dead_frozen", 10'h008, ALL);
      item_step(KEEP);
      e = sb.pop_front(); checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
      item_step(KEEP | AID);
      e = sb.pop_front(); checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    end
  endtask

  task automatic test_async_reset();
    restart();
    for (int k = 0; k < 9; k++) item_step(KEEP);
    push("t6_dying", 10'h0A1, ALL);
    push("t6_async_clear", 10'h000, ALL);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    #2;
    resetn = 1'b0;
    game_active = 1'b0;
    #1;
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    @(posedge clk); #1;
    resetn = 1'b1;
    cycle();
    push("t6_idle_holds", 10'h000, ALL);
    ticks(6);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
    game_active = 1'b1;
    cycle();
    push("t6_after_start", 10'h201, ALL);
    ticks(6);
    e = sb.pop_front(); checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin failures++; $display("FAIL %s: got %b want %b", e.name, obs & e.mask, e.exp & e.mask); end
  endtask

  initial begin
    resetn = 1'b0;
    game_active = 1'b0;
    frame_tick = 1'b0;
    {firstAidGiven, pillsGiven, broomGiven, ballGiven, foodGiven} = 5'b0;
    test_reset();
    test_hunger_set();
    test_food_clear();
    test_item_vs_set();
    test_sleep();
    test_dying(1'b0);
    test_dying(1'b1);
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "time limit reached");
  end

endmodule
